// File: rtl/inst_fetch_unit_pkg.sv
// Shared constants and types for the fetch stage and the control path that drives it.
package inst_fetch_unit_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned SEL_W        = 2;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;

  // Next-PC select encodings; 2'b11 is unassigned and falls back to pc + 4
  localparam logic [SEL_W-1:0] NEXT_PC_SEL_PLUS4  = 2'b00;
  localparam logic [SEL_W-1:0] NEXT_PC_SEL_BRANCH = 2'b01;
  localparam logic [SEL_W-1:0] NEXT_PC_SEL_JUMP   = 2'b10;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/inst_fetch_unit_next_pc_mux.sv
// Combinational next-PC select with the word-alignment check applied to the chosen target.
module inst_fetch_unit_next_pc_mux
  import inst_fetch_unit_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0]  pc_plus_4_i,
  input  logic [SEL_W-1:0] next_pc_select_i,
  input  logic [XLEN-1:0]  branch_target_i,
  input  logic [XLEN-1:0]  jump_target_i,
  output logic [XLEN-1:0]  next_pc_o,
  output logic             misaligned_o
);

  logic [XLEN-1:0] jump_aligned;

  // JALR clears bit 0 of the ALU result before use
  assign jump_aligned = jump_target_i & ~XLEN'(1);

  always_comb begin
    next_pc_o = pc_plus_4_i;
    case (next_pc_select_i)
      NEXT_PC_SEL_PLUS4:  next_pc_o = pc_plus_4_i;
      NEXT_PC_SEL_BRANCH: next_pc_o = branch_target_i;
      NEXT_PC_SEL_JUMP:   next_pc_o = jump_aligned;
      default:            next_pc_o = pc_plus_4_i;
    endcase
  end

  assign misaligned_o = next_pc_o[1];

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the PC, issues one instruction-memory read at a time and holds the
// returned word until the core retires it.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic             clock,
  input  logic             reset,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_resp_valid,
  input  logic [XLEN-1:0]  imem_resp_data,
  output logic [XLEN-1:0]  inst,
  output logic [6:0]       inst_opcode,
  output logic [2:0]       inst_funct3,
  output logic [6:0]       inst_funct7,
  output logic             inst_valid,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_plus_4,
  input  logic             retire,
  input  logic             pc_write_enable,
  input  logic [SEL_W-1:0] next_pc_select,
  input  logic [XLEN-1:0]  branch_target,
  input  logic [XLEN-1:0]  jump_target,
  output logic             fetch_misaligned
);

  fetch_state_t    state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_plus_4_q;
  logic [XLEN-1:0] inst_q;
  logic            inst_valid_q;
  logic            req_valid_q;
  logic            fault_q;

  logic [XLEN-1:0] next_pc_d;
  logic            misaligned_d;

  inst_fetch_unit_next_pc_mux #(
    .XLEN (XLEN)
  ) u_next_pc_mux (
    .pc_plus_4_i      (pc_plus_4_q),
    .next_pc_select_i (next_pc_select),
    .branch_target_i  (branch_target),
    .jump_target_i    (jump_target),
    .next_pc_o        (next_pc_d),
    .misaligned_o     (misaligned_d)
  );

  // Request valid rises the cycle after entering FETCH, so a request only counts once it is visible
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      pc_plus_4_q  <= RESET_PC + XLEN'(4);
      inst_q       <= XLEN'(NOP_INST);
      inst_valid_q <= 1'b0;
      req_valid_q  <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (req_valid_q && imem_req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= WAIT;
          end else begin
            req_valid_q <= 1'b1;
          end
        end
        WAIT: begin
          if (imem_resp_valid) begin
            inst_q       <= imem_resp_data;
            inst_valid_q <= 1'b1;
            state_q      <= HOLD;
          end
        end
        HOLD: begin
          if (retire) begin
            if (!pc_write_enable) begin
              inst_valid_q <= 1'b0;
              req_valid_q  <= 1'b1;
              state_q      <= FETCH;
            end else if (misaligned_d) begin
              fault_q      <= 1'b1;
              inst_valid_q <= 1'b0;
              state_q      <= FAULT;
            end else begin
              pc_q         <= next_pc_d;
              pc_plus_4_q  <= next_pc_d + XLEN'(4);
              inst_valid_q <= 1'b0;
              req_valid_q  <= 1'b1;
              state_q      <= FETCH;
            end
          end
        end
        FAULT: begin
          inst_valid_q <= 1'b0;
          req_valid_q  <= 1'b0;
        end
        default: begin
          inst_valid_q <= 1'b0;
          req_valid_q  <= 1'b0;
          state_q      <= FETCH;
        end
      endcase
    end
  end

  assign imem_req_valid   = req_valid_q;
  assign imem_addr        = pc_q;
  assign inst             = inst_q;
  assign inst_opcode      = inst_q[6:0];
  assign inst_funct3      = inst_q[14:12];
  assign inst_funct7      = inst_q[31:25];
  assign inst_valid       = inst_valid_q;
  assign pc               = pc_q;
  assign pc_plus_4        = pc_plus_4_q;
  assign fetch_misaligned = fault_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed testbench for inst_fetch_unit with hand-computed expectations.
module tb_inst_fetch_unit;

  logic        clock;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic [31:0] inst;
  logic [6:0]  inst_opcode;
  logic [2:0]  inst_funct3;
  logic [6:0]  inst_funct7;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus_4;
  logic        retire;
  logic        pc_write_enable;
  logic [1:0]  next_pc_select;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic        fetch_misaligned;

  int tests_run;
  int tests_failed;

  inst_fetch_unit dut (
    .clock            (clock),
    .reset            (reset),
    .imem_req_valid   (imem_req_valid),
    .imem_req_ready   (imem_req_ready),
    .imem_addr        (imem_addr),
    .imem_resp_valid  (imem_resp_valid),
    .imem_resp_data   (imem_resp_data),
    .inst             (inst),
    .inst_opcode      (inst_opcode),
    .inst_funct3      (inst_funct3),
    .inst_funct7      (inst_funct7),
    .inst_valid       (inst_valid),
    .pc               (pc),
    .pc_plus_4        (pc_plus_4),
    .retire           (retire),
    .pc_write_enable  (pc_write_enable),
    .next_pc_select   (next_pc_select),
    .branch_target    (branch_target),
    .jump_target      (jump_target),
    .fetch_misaligned (fetch_misaligned)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // From FETCH with the request visible: accept, then respond one cycle later
  task automatic fetch_word(input logic [31:0] data);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = data;
    step();
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
  endtask

  task automatic do_retire(input logic pwe, input logic [1:0] sel,
                           input logic [31:0] bt, input logic [31:0] jt);
    retire          = 1'b1;
    pc_write_enable = pwe;
    next_pc_select  = sel;
    branch_target   = bt;
    jump_target     = jt;
    step();
    retire          = 1'b0;
    pc_write_enable = 1'b0;
    next_pc_select  = 2'b00;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    tests_run++;
    if (imem_req_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_req_valid got %0b want 0", imem_req_valid);
    end
    tests_run++;
    if (inst !== 32'h0000_0013) begin
      tests_failed++; $display("FAIL reset_inst got %h want 00000013", inst);
    end
    tests_run++;
    if (inst_valid !== 1'b0 || fetch_misaligned !== 1'b0) begin
      tests_failed++; $display("FAIL reset_flags got valid=%0b fault=%0b want 0/0", inst_valid, fetch_misaligned);
    end
    tests_run++;
    if (pc !== 32'h0040_0000 || pc_plus_4 !== 32'h0040_0004) begin
      tests_failed++; $display("FAIL reset_pc got %h/%h want 00400000/00400004", pc, pc_plus_4);
    end
    step();
    tests_run++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0040_0000) begin
      tests_failed++; $display("FAIL first_req got v=%0b a=%h want 1/00400000", imem_req_valid, imem_addr);
    end
  endtask

  task automatic test_basic_fetch();
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    tests_run++;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
      tests_failed++; $display("FAIL after_accept got req=%0b iv=%0b want 0/0", imem_req_valid, inst_valid);
    end
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0050_0093;
    step();
    imem_resp_valid = 1'b0;
    tests_run++;
    if (inst_valid !== 1'b1 || inst !== 32'h0050_0093) begin
      tests_failed++; $display("FAIL capture got iv=%0b inst=%h want 1/00500093", inst_valid, inst);
    end
    tests_run++;
    if (inst_opcode !== 7'h13 || inst_funct3 !== 3'd0 || inst_funct7 !== 7'h00) begin
      tests_failed++; $display("FAIL decode_addi got %h/%h/%h want 13/0/00", inst_opcode, inst_funct3, inst_funct7);
    end
    // HOLD: idle cycles keep the word
    step();
    tests_run++;
    if (inst_valid !== 1'b1 || imem_req_valid !== 1'b0) begin
      tests_failed++; $display("FAIL hold_idle got iv=%0b req=%0b want 1/0", inst_valid, imem_req_valid);
    end
    do_retire(1'b1, 2'b00, 32'h0, 32'h0);
    tests_run++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0040_0004 || inst_valid !== 1'b0) begin
      tests_failed++; $display("FAIL retire_plus4 got req=%0b a=%h iv=%0b want 1/00400004/0", imem_req_valid, imem_addr, inst_valid);
    end
    tests_run++;
    if (pc_plus_4 !== 32'h0040_0008) begin
      tests_failed++; $display("FAIL pc_plus_4 got %h want 00400008", pc_plus_4);
    end
    // R-type word: funct7=0x20 rs2=2 rs1=1 funct3=5 rd=3 opcode=0x33
    fetch_word(32'h4020_D1B3);
    tests_run++;
    if (inst_opcode !== 7'h33 || inst_funct3 !== 3'd5 || inst_funct7 !== 7'h20) begin
      tests_failed++; $display("FAIL decode_rtype got %h/%h/%h want 33/5/20", inst_opcode, inst_funct3, inst_funct7);
    end
  endtask

  task automatic test_jump();
    do_retire(1'b1, 2'b10, 32'h0, 32'h0040_0101);
    tests_run++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0040_0100) begin
      tests_failed++; $display("FAIL jump_clear_bit0 got req=%0b a=%h want 1/00400100", imem_req_valid, imem_addr);
    end
    fetch_word(32'h0000_0013);
    do_retire(1'b1, 2'b10, 32'h0, 32'h0040_0102);
    tests_run++;
    if (fetch_misaligned !== 1'b1 || imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
      tests_failed++; $display("FAIL jump_misaligned got f=%0b req=%0b iv=%0b want 1/0/0", fetch_misaligned, imem_req_valid, inst_valid);
    end
    tests_run++;
    if (pc !== 32'h0040_0100) begin
      tests_failed++; $display("FAIL fault_pc got %h want 00400100", pc);
    end
    // FAULT is sticky and ignores retire/ready/resp
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_BEEF;
    do_retire(1'b1, 2'b00, 32'h0, 32'h0);
    step();
    step();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    tests_run++;
    if (fetch_misaligned !== 1'b1 || imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || pc !== 32'h0040_0100) begin
      tests_failed++; $display("FAIL fault_sticky got f=%0b req=%0b iv=%0b pc=%h want 1/0/0/00400100", fetch_misaligned, imem_req_valid, inst_valid, pc);
    end
    apply_reset();
    tests_run++;
    if (fetch_misaligned !== 1'b0 || pc !== 32'h0040_0000) begin
      tests_failed++; $display("FAIL fault_reset got f=%0b pc=%h want 0/00400000", fetch_misaligned, pc);
    end
    step();
  endtask

  task automatic test_stall();
    for (int i = 0; i < 5; i++) begin
      imem_resp_valid = (i == 2);
      imem_resp_data  = 32'hDEAD_BEEF;
      step();
      tests_run++;
      if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0040_0000) begin
        tests_failed++; $display("FAIL stall_cycle%0d got req=%0b a=%h want 1/00400000", i, imem_req_valid, imem_addr);
      end
    end
    imem_resp_valid = 1'b0;
    tests_run++;
    if (inst !== 32'h0000_0013 || inst_valid !== 1'b0) begin
      tests_failed++; $display("FAIL stall_resp_ignored got inst=%h iv=%0b want 00000013/0", inst, inst_valid);
    end
    // Accept and response in the same FETCH cycle: response must be dropped
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0BAD_0BAD;
    step();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    tests_run++;
    if (inst !== 32'h0000_0013 || inst_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      tests_failed++; $display("FAIL same_cycle_resp got inst=%h iv=%0b req=%0b want 00000013/0/0", inst, inst_valid, imem_req_valid);
    end
  endtask

  // Entered in WAIT (left there by test_stall)
  task automatic test_reset_in_wait();
    reset = 1'b1;
    step();
    reset = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h1234_5678;
    tests_run++;
    if (imem_req_valid !== 1'b0) begin
      tests_failed++; $display("FAIL wait_reset_req got %0b want 0", imem_req_valid);
    end
    step();
    imem_resp_valid = 1'b0;
    tests_run++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0040_0000 || inst_valid !== 1'b0 || inst !== 32'h0000_0013) begin
      tests_failed++; $display("FAIL late_resp got req=%0b a=%h iv=%0b inst=%h want 1/00400000/0/00000013", imem_req_valid, imem_addr, inst_valid, inst);
    end
  endtask

  task automatic test_wrap_and_refetch();
    // retire outside HOLD is ignored
    retire          = 1'b1;
    pc_write_enable = 1'b1;
    step();
    retire          = 1'b0;
    pc_write_enable = 1'b0;
    tests_run++;
    if (imem_addr !== 32'h0040_0000 || imem_req_valid !== 1'b1) begin
      tests_failed++; $display("FAIL retire_in_fetch got a=%h req=%0b want 00400000/1", imem_addr, imem_req_valid);
    end
    fetch_word(32'h0000_0013);
    do_retire(1'b1, 2'b01, 32'hFFFF_FFFC, 32'h0);
    tests_run++;
    if (imem_addr !== 32'hFFFF_FFFC || pc_plus_4 !== 32'h0000_0000) begin
      tests_failed++; $display("FAIL branch_top got a=%h p4=%h want fffffffc/00000000", imem_addr, pc_plus_4);
    end
    fetch_word(32'h0000_0013);
    do_retire(1'b1, 2'b00, 32'h0, 32'h0);
    tests_run++;
    if (imem_addr !== 32'h0000_0000 || imem_req_valid !== 1'b1) begin
      tests_failed++; $display("FAIL pc_wrap got a=%h req=%0b want 00000000/1", imem_addr, imem_req_valid);
    end
    fetch_word(32'h0000_0013);
    do_retire(1'b0, 2'b01, 32'h0000_1000, 32'h0);
    tests_run++;
    if (imem_addr !== 32'h0000_0000 || imem_req_valid !== 1'b1 || inst_valid !== 1'b0) begin
      tests_failed++; $display("FAIL refetch got a=%h req=%0b iv=%0b want 00000000/1/0", imem_addr, imem_req_valid, inst_valid);
    end
    fetch_word(32'h0000_0013);
    do_retire(1'b1, 2'b11, 32'h0000_1000, 32'h0000_2000);
    tests_run++;
    if (imem_addr !== 32'h0000_0004) begin
      tests_failed++; $display("FAIL sel11_plus4 got a=%h want 00000004", imem_addr);
    end
  endtask

  initial begin
    tests_run       = 0;
    tests_failed    = 0;
    reset           = 1'b1;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    retire          = 1'b0;
    pc_write_enable = 1'b0;
    next_pc_select  = 2'b00;
    branch_target   = 32'h0;
    jump_target     = 32'h0;
    #1;
    test_reset();
    test_basic_fetch();
    test_jump();
    test_stall();
    test_reset_in_wait();
    test_wrap_and_refetch();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
